// File: rtl/rc4_ksa_fsm_if.sv
// RC4 key-scheduling bus: start/key request, S RAM port and status.
// The KSA block uses the master modport because it drives the S RAM
// address/data/write-enable; the surrounding logic uses the slave modport.
interface rc4_ksa_fsm_if #(
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic [7:0]             s_q;
  logic [7:0]             address;
  logic [7:0]             data;
  logic                   s_wren;
  logic                   busy;
  logic                   finish;

  modport master (
    input  start, secret_key, s_q,
    output address, data, s_wren, busy, finish
  );

  modport slave (
    output start, secret_key, s_q,
    input  address, data, s_wren, busy, finish
  );
endinterface

// File: rtl/rc4_ksa_fsm.sv
// RC4 key-scheduling stage. Permutes the 256-entry S-box RAM in place:
//   for i = 0..255: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]
// All RAM-facing outputs are registered and take the value belonging to
// the state being entered, so the address is already on the bus in the
// first cycle of each read state.
// Optional feature macro: INIT_PHASE_EN -- when defined, the block first
// writes the identity permutation S[n] = n itself (256 cycles) before
// scheduling; otherwise the RAM must already hold the identity.
module rc4_ksa_fsm #(
  parameter int KEY_BYTES = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  rc4_ksa_fsm_if.master     bus
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I,
    WT_I,
    LD_I,
    RD_J,
    WT_J,
    LD_J,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } state_t;

  state_t                 state, state_next;
  logic [7:0]             i, i_next;
  logic [7:0]             j, j_next;
  logic [KIDX_W-1:0]      kidx, kidx_next;
  logic [7:0]             si, si_next;
  logic [8*KEY_BYTES-1:0] key_reg, key_next;
  logic [7:0]             address_r, address_next;
  logic [7:0]             data_r, data_next;
  logic                   wren_r, wren_next;
  logic                   busy_r, busy_next;
  logic                   finish_r, finish_next;
  logic [7:0]             key_byte;
  logic [7:0]             j_sum;

  // Select the current key byte; byte 0 is the most significant byte of the key.
  always_comb begin
    key_byte = 8'h00;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx == KIDX_W'(k)) begin
        key_byte = key_reg[8*(KEY_BYTES-k)-1 -: 8];
      end
    end
  end

  // Next-state, datapath and registered-output values; S[j] is forwarded
  // straight from s_q into the WR_I write data, so no separate sj register.
  always_comb begin
    state_next   = state;
    i_next       = i;
    j_next       = j;
    kidx_next    = kidx;
    si_next      = si;
    key_next     = key_reg;
    address_next = address_r;
    data_next    = data_r;
    wren_next    = 1'b0;
    finish_next  = 1'b0;
    j_sum        = j + bus.s_q + key_byte;

    case (state)
      IDLE: begin
        if (bus.start) begin
          key_next     = bus.secret_key;
          i_next       = 8'd0;
          j_next       = 8'd0;
          kidx_next    = '0;
          address_next = 8'd0;
`ifdef INIT_PHASE_EN
          data_next    = 8'd0;
          wren_next    = 1'b1;
          state_next   = INIT;
`else
          state_next   = RD_I;
`endif
        end
      end
`ifdef INIT_PHASE_EN
      INIT: begin
        if (i == 8'd255) begin
          i_next       = 8'd0;
          address_next = 8'd0;
          state_next   = RD_I;
        end else begin
          i_next       = i + 8'd1;
          address_next = i + 8'd1;
          data_next    = i + 8'd1;
          wren_next    = 1'b1;
        end
      end
`endif
      RD_I: state_next = WT_I;
      WT_I: state_next = LD_I;
      LD_I: begin
        si_next      = bus.s_q;
        j_next       = j_sum;
        address_next = j_sum;
        state_next   = RD_J;
      end
      RD_J: state_next = WT_J;
      WT_J: state_next = LD_J;
      LD_J: begin
        address_next = i;
        data_next    = bus.s_q;
        wren_next    = 1'b1;
        state_next   = WR_I;
      end
      WR_I: begin
        address_next = j;
        data_next    = si;
        wren_next    = 1'b1;
        state_next   = WR_J;
      end
      WR_J: state_next = NEXT;
      NEXT: begin
        if (i == 8'd255) begin
          finish_next = 1'b1;
          state_next  = DONE;
        end else begin
          i_next       = i + 8'd1;
          address_next = i + 8'd1;
          if (kidx == KIDX_W'(KEY_BYTES-1)) begin
            kidx_next = '0;
          end else begin
            kidx_next = kidx + 1'b1;
          end
          state_next = RD_I;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      i         <= 8'd0;
      j         <= 8'd0;
      kidx      <= '0;
      si        <= 8'd0;
      key_reg   <= '0;
      address_r <= 8'd0;
      data_r    <= 8'd0;
      wren_r    <= 1'b0;
      busy_r    <= 1'b0;
      finish_r  <= 1'b0;
    end else begin
      state     <= state_next;
      i         <= i_next;
      j         <= j_next;
      kidx      <= kidx_next;
      si        <= si_next;
      key_reg   <= key_next;
      address_r <= address_next;
      data_r    <= data_next;
      wren_r    <= wren_next;
      busy_r    <= busy_next;
      finish_r  <= finish_next;
    end
  end

  assign bus.address = address_r;
  assign bus.data    = data_r;
  assign bus.s_wren  = wren_r;
  assign bus.busy    = busy_r;
  assign bus.finish  = finish_r;

endmodule
